dmem_lsu: RTL

DMEM_LSU -- requirements
Module: dmem_lsu

---
 rtl/dmem_lsu.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/dmem_lsu.sv
// Load/store unit between a CPU and a word-wide data memory: sub-word loads, RMW sub-word stores, range check.
// Optional macro DMEM_LSU_ALIGN_CHECK_EN: misaligned accesses go to ERR and raise an extra misalign output.
module dmem_lsu #(
    parameter int unsigned DEPTH = 2048
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req,
    input  logic        we,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic        busy,
    output logic        done,
    output logic [31:0] rdata,
    output logic        DM_CS,
    output logic        DM_R,
    output logic        DM_W,
    output logic [31:0] addr,
    output logic [31:0] data_in,
    input  logic [31:0] data_out
`ifdef DMEM_LSU_ALIGN_CHECK_EN
    ,
    output logic        misalign
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_WR,
        S_DONE,
        S_ERR
    } state_t;

    state_t      r_state;
    state_t      w_next;

    logic [29:0] r_addr;
    logic [1:0]  r_lo;
    logic [1:0]  r_size;
    logic        r_we;
    logic        r_sext;
    logic [31:0] r_wdata;
    logic [31:0] r_word;
    logic [31:0] r_rdata;

    logic        w_is_word_in;
    logic        w_is_half_in;
    logic        w_oor;
    logic        w_misalign_in;
    logic [1:0]  w_lo_in;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_ext;
    logic [31:0] w_merge;

    assign w_is_word_in = size[1];
    assign w_is_half_in = (size == 2'b01);
    assign w_oor        = ({2'b00, cpu_addr[31:2]} >= DEPTH);

`ifdef DMEM_LSU_ALIGN_CHECK_EN
    logic r_misalign;

    assign w_misalign_in = (w_is_half_in && cpu_addr[0]) || (w_is_word_in && (cpu_addr[1:0] != 2'b00));
    assign w_lo_in       = cpu_addr[1:0];
    assign misalign      = (r_state == S_ERR) && r_misalign;
`else
    // Misaligned low bits are dropped so the access lands on the enclosing aligned lane.
    assign w_misalign_in = 1'b0;
    assign w_lo_in       = w_is_word_in ? 2'b00 :
                           w_is_half_in ? {cpu_addr[1], 1'b0} : cpu_addr[1:0];
`endif

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (req) begin
                    if (w_oor || w_misalign_in) begin
                        w_next = S_ERR;
                    end else if (we && w_is_word_in) begin
                        w_next = S_WR;
                    end else begin
                        w_next = S_RD;
                    end
                end
            end
            S_RD:    w_next = r_we ? S_WR : S_DONE;
            S_WR:    w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            S_ERR:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_byte = data_out[7:0];
        case (r_lo)
            2'b01:   w_byte = data_out[15:8];
            2'b10:   w_byte = data_out[23:16];
            2'b11:   w_byte = data_out[31:24];
            default: w_byte = data_out[7:0];
        endcase
        w_half = r_lo[1] ? data_out[31:16] : data_out[15:0];
        case (r_size)
            2'b00:   w_ext = {{24{r_sext & w_byte[7]}}, w_byte};
            2'b01:   w_ext = {{16{r_sext & w_half[15]}}, w_half};
            default: w_ext = data_out;
        endcase
    end

    always_comb begin
        w_merge = r_word;
        case (r_size)
            2'b00: begin
                case (r_lo)
                    2'b01:   w_merge[15:8]  = r_wdata[7:0];
                    2'b10:   w_merge[23:16] = r_wdata[7:0];
                    2'b11:   w_merge[31:24] = r_wdata[7:0];
                    default: w_merge[7:0]   = r_wdata[7:0];
                endcase
            end
            2'b01: begin
                if (r_lo[1]) begin
                    w_merge[31:16] = r_wdata[15:0];
                end else begin
                    w_merge[15:0] = r_wdata[15:0];
                end
            end
            default: w_merge = r_wdata;
        endcase
    end

    assign busy    = (r_state != S_IDLE);
    assign done    = (r_state == S_DONE) || (r_state == S_ERR);
    assign DM_CS   = (r_state == S_RD) || (r_state == S_WR);
    assign DM_R    = (r_state == S_RD);
    assign DM_W    = (r_state == S_WR);
    assign addr    = {r_addr, 2'b00};
    assign data_in = w_merge;
    assign rdata   = r_rdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_addr  <= '0;
            r_lo    <= '0;
            r_size  <= '0;
            r_we    <= 1'b0;
            r_sext  <= 1'b0;
            r_wdata <= '0;
            r_word  <= '0;
            r_rdata <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_IDLE && req) begin
                r_addr  <= cpu_addr[31:2];
                r_lo    <= w_lo_in;
                r_size  <= size;
                r_we    <= we;
                r_sext  <= sign_ext;
                r_wdata <= cpu_wdata;
            end
            if (r_state == S_RD) begin
                r_word <= data_out;
                if (!r_we) begin
                    r_rdata <= w_ext;
                end
            end
            if (r_state == S_IDLE && w_next == S_ERR) begin
                r_rdata <= '0;
            end
        end
    end

`ifdef DMEM_LSU_ALIGN_CHECK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_misalign <= 1'b0;
        end else if (r_state == S_IDLE && req) begin
            r_misalign <= w_misalign_in;
        end
    end
`endif

endmodule
